// File: rtl/max_min_stream_feeder_if.sv
// Memory read port and accelerator handshake bundled between the feeder (master)
// and the memory/accelerator side (slave).
`ifndef FE_DATA_W
`define FE_DATA_W 32
`endif

interface max_min_stream_feeder_if #(
  parameter int DATA_W = `FE_DATA_W,
  parameter int ADDR_W = 32
);
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              acc_clr_o;
  logic              acc_start_o;
  logic [DATA_W-1:0] acc_data_o;
  logic              acc_done_i;
  logic [DATA_W-1:0] acc_data_i;

  modport master (
    output mem_req_o, mem_addr_o, acc_clr_o, acc_start_o, acc_data_o,
    input  mem_rvalid_i, mem_rdata_i, acc_done_i, acc_data_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, acc_clr_o, acc_start_o, acc_data_o,
    output mem_rvalid_i, mem_rdata_i, acc_done_i, acc_data_i
  );
endinterface

// File: rtl/max_min_stream_feeder.sv
// Job sequencer for the max/min accelerator: clears it, streams num_words memory
// words through its start/done handshake and returns the final {max,min} result.
//
// state   | meaning
// IDLE    | waiting for cmd_start_i
// CLEAR   | accelerator held in reset for one cycle
// REQ     | single-cycle memory read request
// WAIT    | waiting for read data
// START   | acc_start_o high until acc_done_i
// RELEASE | acc_start_o low until acc_done_i drops
// FINISH  | cmd_done_o pulse
`ifndef FE_DATA_W
`define FE_DATA_W 32
`endif

module max_min_stream_feeder #(
  parameter int DATA_W    = `FE_DATA_W,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   cmd_start_i,
  input  logic [ADDR_W-1:0]      base_addr_i,
  input  logic [CNT_W-1:0]       num_words_i,
  output logic                   busy_o,
  output logic                   cmd_done_o,
  output logic [DATA_W-1:0]      result_o,
  max_min_stream_feeder_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_REQ, S_WAIT, S_START, S_RELEASE, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] result_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (cmd_start_i) state_d = S_CLEAR;
      S_CLEAR:   state_d = (rem_q == '0) ? S_FINISH : S_REQ;
      S_REQ:     state_d = S_WAIT;
      S_WAIT:    if (bus.mem_rvalid_i) state_d = S_START;
      S_START:   if (bus.acc_done_i) state_d = S_RELEASE;
      S_RELEASE: if (!bus.acc_done_i) state_d = (rem_q == CNT_W'(1)) ? S_FINISH : S_REQ;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      addr_q   <= '0;
      rem_q    <= '0;
      word_q   <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_start_i) begin
            addr_q <= base_addr_i;
            rem_q  <= num_words_i;
          end
        end
        S_CLEAR: result_q <= '0;
        S_WAIT:  if (bus.mem_rvalid_i) word_q <= bus.mem_rdata_i;
        S_START: if (bus.acc_done_i) result_q <= bus.acc_data_i;
        S_RELEASE: begin
          if (!bus.acc_done_i) begin
            rem_q <= rem_q - CNT_W'(1);
            // Address only advances when another word follows; wraps naturally.
            if (rem_q != CNT_W'(1)) addr_q <= addr_q + ADDR_W'(ADDR_STEP);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o          = (state_q != S_IDLE);
  assign cmd_done_o      = (state_q == S_FINISH);
  assign result_o        = result_q;
  assign bus.mem_req_o   = (state_q == S_REQ);
  assign bus.mem_addr_o  = addr_q;
  assign bus.acc_start_o = (state_q == S_START);
  assign bus.acc_data_o  = word_q;
  // Accelerator is also held clear for as long as our own reset is asserted.
  assign bus.acc_clr_o   = (state_q == S_CLEAR) | ~rst_n_i;

endmodule

// File: tb/tb_max_min_stream_feeder.sv
// Directed bench for max_min_stream_feeder with a behavioural memory and a
// single-cycle max/min accelerator model.
`timescale 1ns/1ps

module tb_max_min_stream_feeder;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        cmd_start_i;
  logic [31:0] base_addr_i;
  logic [15:0] num_words_i;
  logic        busy_o;
  logic        cmd_done_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_bad = 0;

  max_min_stream_feeder_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  max_min_stream_feeder #(.DATA_W(32), .ADDR_W(32), .CNT_W(16), .ADDR_STEP(4)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .cmd_start_i (cmd_start_i),
    .base_addr_i (base_addr_i),
    .num_words_i (num_words_i),
    .busy_o      (busy_o),
    .cmd_done_o  (cmd_done_o),
    .result_o    (result_o),
    .bus         (bus)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: returns queued words in order, mem_delay cycles after a request.
  logic [31:0] rdata_q[$];
  logic [31:0] req_log[$];
  int          mem_delay = 1;
  logic        mem_pend;
  int          mem_cnt;

  always @(posedge clk_i) begin
    if (!rst_n_i) begin
      mem_pend         <= 1'b0;
      mem_cnt          <= 0;
      bus.mem_rvalid_i <= 1'b0;
      bus.mem_rdata_i  <= '0;
    end else begin
      bus.mem_rvalid_i <= 1'b0;
      if (bus.mem_req_o) begin
        req_log.push_back(bus.mem_addr_o);
        if (mem_delay <= 1) begin
          bus.mem_rvalid_i <= 1'b1;
          bus.mem_rdata_i  <= (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hDEAD_BEEF;
        end else begin
          mem_pend <= 1'b1;
          mem_cnt  <= mem_delay - 1;
        end
      end else if (mem_pend) begin
        if (mem_cnt == 1) begin
          bus.mem_rvalid_i <= 1'b1;
          bus.mem_rdata_i  <= (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'hDEAD_BEEF;
          mem_pend         <= 1'b0;
        end
        mem_cnt <= mem_cnt - 1;
      end
    end
  end

  // Accelerator model: running max/min over byte lanes, done one cycle after start.
  logic [7:0] acc_max, acc_min;
  int         clr_cnt = 0;

  always @(posedge clk_i) begin
    if (bus.acc_clr_o) begin
      acc_max        <= 8'h00;
      acc_min        <= 8'hFF;
      bus.acc_done_i <= 1'b0;
      if (rst_n_i) clr_cnt <= clr_cnt + 1;
    end else if (bus.acc_start_o && !bus.acc_done_i) begin
      logic [7:0] mx, mn;
      mx = acc_max;
      mn = acc_min;
      for (int l = 0; l < 4; l++) begin
        if (bus.acc_data_o[l*8 +: 8] > mx) mx = bus.acc_data_o[l*8 +: 8];
        if (bus.acc_data_o[l*8 +: 8] < mn) mn = bus.acc_data_o[l*8 +: 8];
      end
      acc_max        <= mx;
      acc_min        <= mn;
      bus.acc_done_i <= 1'b1;
    end else if (!bus.acc_start_o) begin
      bus.acc_done_i <= 1'b0;
    end
  end

  assign bus.acc_data_i = {16'h0000, acc_max, acc_min};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [31:0] base, input logic [15:0] n,
                         output int busy_cyc, output int done_at, output logic [31:0] res);
    busy_cyc = 0;
    done_at  = -1;
    res      = 32'hxxxx_xxxx;
    @(negedge clk_i);
    cmd_start_i = 1'b1;
    base_addr_i = base;
    num_words_i = n;
    @(negedge clk_i);
    cmd_start_i = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy_o) busy_cyc++;
      if (cmd_done_o) begin
        done_at = i;
        res     = result_o;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  int          busy_cyc, done_at, bad, clr0;
  logic [31:0] res;

  initial begin
    rst_n_i     = 1'b0;
    cmd_start_i = 1'b0;
    base_addr_i = '0;
    num_words_i = '0;
    repeat (3) @(negedge clk_i);

    // Reset state
    check("rst_busy",      busy_o,          32'd0);
    check("rst_done",      cmd_done_o,      32'd0);
    check("rst_mem_req",   bus.mem_req_o,   32'd0);
    check("rst_acc_start", bus.acc_start_o, 32'd0);
    check("rst_mem_addr",  bus.mem_addr_o,  32'd0);
    check("rst_acc_data",  bus.acc_data_o,  32'd0);
    check("rst_result",    result_o,        32'd0);
    check("rst_acc_clr",   bus.acc_clr_o,   32'd1);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("idle_acc_clr",  bus.acc_clr_o,   32'd0);

    // 1: single word
    req_log.delete();
    rdata_q.push_back(32'h1020_3040);
    clr0 = clr_cnt;
    run_job(32'h100, 16'd1, busy_cyc, done_at, res);
    check("t1_done_at", done_at,        32'd7);
    check("t1_result",  res,            32'h0000_4010);
    check("t1_busy",    busy_cyc,       32'd8);
    check("t1_nreq",    req_log.size(), 32'd1);
    check("t1_addr",    req_log[0],     32'h100);
    check("t1_clr",     clr_cnt - clr0, 32'd1);

    // 2: two words accumulate
    req_log.delete();
    rdata_q.push_back(32'h0102_0304);
    rdata_q.push_back(32'h80FF_0010);
    run_job(32'h100, 16'd2, busy_cyc, done_at, res);
    check("t2_result", res,            32'h0000_FF00);
    check("t2_busy",   busy_cyc,       32'd14);
    check("t2_nreq",   req_log.size(), 32'd2);
    check("t2_addr0",  req_log[0],     32'h100);
    check("t2_addr1",  req_log[1],     32'h104);

    // 3: back-to-back jobs, accelerator cleared in each
    rdata_q.push_back(32'hFFFF_FFFF);
    clr0 = clr_cnt;
    run_job(32'h400, 16'd1, busy_cyc, done_at, res);
    check("t3_job1_result", res,            32'h0000_FFFF);
    check("t3_job1_clr",    clr_cnt - clr0, 32'd1);
    rdata_q.push_back(32'h0505_0505);
    run_job(32'h500, 16'd1, busy_cyc, done_at, res);
    check("t3_job2_result", res,            32'h0000_0505);
    check("t3_job2_clr",    clr_cnt - clr0, 32'd2);

    // 4: zero-length job
    req_log.delete();
    run_job(32'h600, 16'd0, busy_cyc, done_at, res);
    check("t4_done_at", done_at,        32'd1);
    check("t4_busy",    busy_cyc,       32'd2);
    check("t4_result",  res,            32'd0);
    check("t4_nreq",    req_log.size(), 32'd0);

    // 5: slow memory, FSM parks in WAIT
    mem_delay = 10;
    rdata_q.push_back(32'h1122_3344);
    @(negedge clk_i);
    cmd_start_i = 1'b1;
    base_addr_i = 32'h700;
    num_words_i = 16'd1;
    @(negedge clk_i);
    cmd_start_i = 1'b0;
    busy_cyc = 0;
    done_at  = -1;
    bad      = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy_o) busy_cyc++;
      if (i >= 2 && i <= 11 && (bus.acc_start_o || result_o != 32'd0 || !busy_o || bus.mem_req_o)) bad++;
      if (i == 12) check("t5_start_after_rvalid", bus.acc_start_o, 32'd1);
      if (cmd_done_o) begin
        done_at = i;
        res     = result_o;
        break;
      end
      @(negedge clk_i);
    end
    check("t5_wait_hold", bad,      32'd0);
    check("t5_done_at",   done_at,  32'd16);
    check("t5_busy",      busy_cyc, 32'd17);
    check("t5_result",    res,      32'h0000_4411);
    mem_delay = 1;

    // 6: stray start while busy, then reset during START
    req_log.delete();
    rdata_q.push_back(32'h0101_0101);
    rdata_q.push_back(32'h0202_0202);
    @(negedge clk_i);
    cmd_start_i = 1'b1;
    base_addr_i = 32'h200;
    num_words_i = 16'd2;
    @(negedge clk_i);
    cmd_start_i = 1'b0;
    @(negedge clk_i);
    cmd_start_i = 1'b1;
    base_addr_i = 32'h900;
    num_words_i = 16'd1;
    @(negedge clk_i);
    cmd_start_i = 1'b0;
    bad = 1;
    for (int i = 0; i < 50; i++) begin
      if (req_log.size() == 2 && bus.acc_start_o) begin
        bad = 0;
        break;
      end
      @(negedge clk_i);
    end
    check("t6_reach_start2", bad,            32'd0);
    check("t6_nreq",         req_log.size(), 32'd2);
    check("t6_addr1",        req_log[1],     32'h204);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    check("t6_rst_busy",      busy_o,          32'd0);
    check("t6_rst_acc_start", bus.acc_start_o, 32'd0);
    check("t6_rst_mem_req",   bus.mem_req_o,   32'd0);
    check("t6_rst_mem_addr",  bus.mem_addr_o,  32'd0);
    check("t6_rst_acc_data",  bus.acc_data_o,  32'd0);
    check("t6_rst_result",    result_o,        32'd0);
    check("t6_rst_acc_clr",   bus.acc_clr_o,   32'd1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    rdata_q.delete();
    busy_cyc = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (busy_o) busy_cyc++;
    end
    check("t6_idle_after_rst", busy_cyc, 32'd0);
    rdata_q.push_back(32'h0A0B_0C0D);
    run_job(32'h300, 16'd1, busy_cyc, done_at, res);
    check("t6_post_result", res,      32'h0000_0D0A);
    check("t6_post_busy",   busy_cyc, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
